// File: rtl/sm_pkg.sv
// Shared definitions for the program-ROM arbiter slice.
// Contents:
//   REQ_F / REQ_D     requester indices into the one-hot grant vector
//   PRIO_RR / PRIO_FIXED  arbitration policy selectors
//   addr_err()        flags misaligned or out-of-range ROM byte addresses
package sm_pkg;

   localparam int REQ_F      = 0;
   localparam int REQ_D      = 1;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   // The address is bad if it is not word aligned or its word index is past the ROM end.
   function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] size);
      logic [31:0] idx_s;
      idx_s = {2'b00, addr[31:2]};
      return (addr[1:0] != 2'b00) || (idx_s >= size);
   endfunction

endpackage

// File: rtl/sm_rom_arbiter_if.sv
// One requester's ROM read channel.
// Signals:
//   req     request, held with addr stable until gnt
//   addr    byte address
//   gnt     request accepted this cycle
//   rvalid  response valid, one cycle after gnt
//   rdata   response word
//   err     response error, qualified by rvalid
// Modports: master = requester side, slave = arbiter side.
interface sm_rom_arbiter_if;

   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, output addr, input gnt, input rvalid, input rdata, input err);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata, output err);

endinterface

// File: rtl/sm_arb2.sv
// Two-way grant logic for the ROM port.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   f_req, d_req    fetch / data requests
//   gnt[1:0]        one-hot grant (bit REQ_F / REQ_D), combinational
// PRIO_MODE selects round-robin or fixed priority to F; in fixed mode a
// starvation counter forces a D grant after STARVE_LIMIT denied cycles.
module sm_arb2
   import sm_pkg::*;
#(
   parameter int PRIO_MODE    = PRIO_RR,
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       f_req,
   input  logic       d_req,
   output logic [1:0] gnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic       last_grant_r;
   logic [3:0] starve_cnt_r;
   logic [1:0] gnt_s;
   logic       starved_s;

   assign starved_s = (starve_cnt_r == LIMIT);

   // Grant selection: a single requester always wins; ties resolved by policy.
   always_comb begin
      gnt_s = 2'b00;
      if (PRIO_MODE == PRIO_FIXED) begin
         if (d_req && starved_s) begin
            gnt_s[REQ_D] = 1'b1;
         end else if (f_req) begin
            gnt_s[REQ_F] = 1'b1;
         end else if (d_req) begin
            gnt_s[REQ_D] = 1'b1;
         end else begin
            gnt_s = 2'b00;
         end
      end else begin
         if (f_req && d_req) begin
            // Alternate: the side not granted last time wins the tie.
            if (last_grant_r == 1'(REQ_F)) begin
               gnt_s[REQ_D] = 1'b1;
            end else begin
               gnt_s[REQ_F] = 1'b1;
            end
         end else if (f_req) begin
            gnt_s[REQ_F] = 1'b1;
         end else if (d_req) begin
            gnt_s[REQ_D] = 1'b1;
         end else begin
            gnt_s = 2'b00;
         end
      end
   end

   assign gnt = gnt_s;

   // Arbitration history: last granted side and D starvation count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= 1'(REQ_D);
         starve_cnt_r <= 4'd0;
      end else begin
         if (gnt_s[REQ_F]) begin
            last_grant_r <= 1'(REQ_F);
         end else if (gnt_s[REQ_D]) begin
            last_grant_r <= 1'(REQ_D);
         end else begin
            last_grant_r <= last_grant_r;
         end

         // Counts only denied D cycles; any D grant or withdrawn d_req clears it.
         if ((PRIO_MODE == PRIO_FIXED) && d_req && !gnt_s[REQ_D]) begin
            if (starve_cnt_r != LIMIT) begin
               starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
               starve_cnt_r <= starve_cnt_r;
            end
         end else begin
            starve_cnt_r <= 4'd0;
         end
      end
   end

endmodule

// File: rtl/sm_rom_arbiter.sv
// Shares the combinational program-ROM read port between instruction fetch
// (F) and data-side constant loads (D).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   f_bus        fetch channel (slave side)
//   d_bus        data channel (slave side)
//   mem_a        ROM byte address, follows the granted requester (0 when idle)
//   mem_rd       ROM word, combinational from mem_a
// Responses are registered: rvalid/rdata/err appear one cycle after gnt.
module sm_rom_arbiter
   import sm_pkg::*;
#(
   parameter int SIZE         = 64,
   parameter int PRIO_MODE    = PRIO_RR,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   sm_rom_arbiter_if.slave   f_bus,
   sm_rom_arbiter_if.slave   d_bus,
   output logic [31:0]       mem_a,
   input  logic [31:0]       mem_rd
);

   logic [1:0]  gnt_s;
   logic [31:0] mem_a_s;
   logic        err_s;
   logic [31:0] rdata_s;

   logic        f_rvalid_r;
   logic [31:0] f_rdata_r;
   logic        f_err_r;
   logic        d_rvalid_r;
   logic [31:0] d_rdata_r;
   logic        d_err_r;

   sm_arb2 #(
      .PRIO_MODE    (PRIO_MODE),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .f_req (f_bus.req),
      .d_req (d_bus.req),
      .gnt   (gnt_s)
   );

   // Address mux and same-cycle read data qualification.
   always_comb begin
      if (gnt_s[REQ_F]) begin
         mem_a_s = f_bus.addr;
      end else if (gnt_s[REQ_D]) begin
         mem_a_s = d_bus.addr;
      end else begin
         mem_a_s = 32'h0;
      end
      err_s   = addr_err(mem_a_s, 32'(SIZE));
      rdata_s = err_s ? 32'h0 : mem_rd;
   end

   // Response registers; rvalid is a one-cycle pulse per grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_rvalid_r <= 1'b0;
         f_rdata_r  <= 32'h0;
         f_err_r    <= 1'b0;
         d_rvalid_r <= 1'b0;
         d_rdata_r  <= 32'h0;
         d_err_r    <= 1'b0;
      end else begin
         f_rvalid_r <= gnt_s[REQ_F];
         f_err_r    <= gnt_s[REQ_F] & err_s;
         d_rvalid_r <= gnt_s[REQ_D];
         d_err_r    <= gnt_s[REQ_D] & err_s;
         if (gnt_s[REQ_F]) begin
            f_rdata_r <= rdata_s;
         end else begin
            f_rdata_r <= f_rdata_r;
         end
         if (gnt_s[REQ_D]) begin
            d_rdata_r <= rdata_s;
         end else begin
            d_rdata_r <= d_rdata_r;
         end
      end
   end

   assign mem_a        = mem_a_s;
   assign f_bus.gnt    = gnt_s[REQ_F];
   assign f_bus.rvalid = f_rvalid_r;
   assign f_bus.rdata  = f_rdata_r;
   assign f_bus.err    = f_err_r;
   assign d_bus.gnt    = gnt_s[REQ_D];
   assign d_bus.rvalid = d_rvalid_r;
   assign d_bus.rdata  = d_rdata_r;
   assign d_bus.err    = d_err_r;

endmodule

// File: tb/tb_sm_rom_arbiter.sv
// Directed bench: u0 is round-robin, u1 is fixed priority (STARVE_LIMIT 4).
// ROM model: word i = 32'h1000_0000 + i.
module tb_sm_rom_arbiter;
   import sm_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_a0, mem_rd0, mem_a1, mem_rd1;
   int          errors;
   int          checks;

   sm_rom_arbiter_if f0 ();
   sm_rom_arbiter_if d0 ();
   sm_rom_arbiter_if f1 ();
   sm_rom_arbiter_if d1 ();

   sm_rom_arbiter #(.SIZE(64), .PRIO_MODE(PRIO_RR), .STARVE_LIMIT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .f_bus(f0), .d_bus(d0), .mem_a(mem_a0), .mem_rd(mem_rd0));

   sm_rom_arbiter #(.SIZE(64), .PRIO_MODE(PRIO_FIXED), .STARVE_LIMIT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .f_bus(f1), .d_bus(d1), .mem_a(mem_a1), .mem_rd(mem_rd1));

   assign mem_rd0 = 32'h1000_0000 + {2'b00, mem_a0[31:2]};
   assign mem_rd1 = 32'h1000_0000 + {2'b00, mem_a1[31:2]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      f0.req = 1'b0; f0.addr = 32'h0; d0.req = 1'b0; d0.addr = 32'h0;
      f1.req = 1'b0; f1.addr = 32'h0; d1.req = 1'b0; d1.addr = 32'h0;

      // Reset state
      #3;
      chk("rst_f_rvalid", 32'(f0.rvalid), 32'h0);
      chk("rst_d_rvalid", 32'(d0.rvalid), 32'h0);
      chk("rst_f_rdata", f0.rdata, 32'h0);
      chk("rst_d_err", 32'(d1.err), 32'h0);
      chk("rst_gnt", {30'h0, f0.gnt, d0.gnt}, 32'h0);
      chk("rst_mem_a", mem_a0, 32'h0);
      #4 rst_n = 1'b1;
      cyc();

      // Single fetch on u1
      f1.req = 1'b1; f1.addr = 32'h8;
      #1;
      chk("single_f_gnt", 32'(f1.gnt), 32'h1);
      chk("single_d_gnt", 32'(d1.gnt), 32'h0);
      chk("single_mem_a", mem_a1, 32'h8);
      cyc();
      f1.req = 1'b0;
      chk("single_f_rvalid", 32'(f1.rvalid), 32'h1);
      chk("single_f_rdata", f1.rdata, 32'h1000_0002);
      chk("single_f_err", 32'(f1.err), 32'h0);
      chk("single_d_rvalid", 32'(d1.rvalid), 32'h0);
      cyc();
      chk("single_pulse_end", 32'(f1.rvalid), 32'h0);

      // Round-robin contention on u0: F, D, F, D
      f0.req = 1'b1; f0.addr = 32'h0; d0.req = 1'b1; d0.addr = 32'h4;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_f_gnt", 32'(f0.gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
         chk("rr_d_gnt", 32'(d0.gnt), (i % 2 == 0) ? 32'h0 : 32'h1);
         chk("rr_mem_a", mem_a0, (i % 2 == 0) ? 32'h0 : 32'h4);
         cyc();
         chk("rr_f_rvalid", 32'(f0.rvalid), (i % 2 == 0) ? 32'h1 : 32'h0);
         chk("rr_d_rvalid", 32'(d0.rvalid), (i % 2 == 0) ? 32'h0 : 32'h1);
         if (i % 2 == 0) chk("rr_f_rdata", f0.rdata, 32'h1000_0000);
         else            chk("rr_d_rdata", d0.rdata, 32'h1000_0001);
      end
      f0.req = 1'b0; d0.req = 1'b0;
      cyc();
      chk("rr_idle_rvalid", {30'h0, f0.rvalid, d0.rvalid}, 32'h0);

      // Fixed priority starvation on u1: F x4, D, F
      f1.req = 1'b1; f1.addr = 32'h10; d1.req = 1'b1; d1.addr = 32'hC;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("starve_f_gnt", 32'(f1.gnt), (i == 4) ? 32'h0 : 32'h1);
         chk("starve_d_gnt", 32'(d1.gnt), (i == 4) ? 32'h1 : 32'h0);
         cyc();
         if (i == 4) begin
            chk("starve_d_rvalid", 32'(d1.rvalid), 32'h1);
            chk("starve_d_rdata", d1.rdata, 32'h1000_0003);
            chk("starve_cnt_clr", 32'(u1.u_arb.starve_cnt_r), 32'h0);
         end else begin
            chk("starve_f_rdata", f1.rdata, 32'h1000_0004);
         end
      end
      f1.req = 1'b0; d1.req = 1'b0;
      cyc();

      // Withdrawn D request on u1
      f1.req = 1'b1; d1.req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("wd_d_gnt", 32'(d1.gnt), 32'h0);
         cyc();
         chk("wd_d_rvalid", 32'(d1.rvalid), 32'h0);
      end
      f1.req = 1'b0; d1.req = 1'b0;
      #1;
      chk("wd_d_gnt_off", 32'(d1.gnt), 32'h0);
      cyc();
      chk("wd_d_rvalid_off", 32'(d1.rvalid), 32'h0);
      chk("wd_starve_cnt", 32'(u1.u_arb.starve_cnt_r), 32'h0);

      // Error responses on u0
      d0.req = 1'b1; d0.addr = 32'h6;
      #1;
      chk("err_d_gnt", 32'(d0.gnt), 32'h1);
      cyc();
      d0.req = 1'b0;
      chk("err_d_rvalid", 32'(d0.rvalid), 32'h1);
      chk("err_d_err", 32'(d0.err), 32'h1);
      chk("err_d_rdata", d0.rdata, 32'h0);
      f0.req = 1'b1; f0.addr = 32'h100;
      cyc();
      chk("err_f_rvalid", 32'(f0.rvalid), 32'h1);
      chk("err_f_err", 32'(f0.err), 32'h1);
      chk("err_f_rdata", f0.rdata, 32'h0);
      f0.addr = 32'hFC;
      cyc();
      f0.req = 1'b0;
      chk("last_word_err", 32'(f0.err), 32'h0);
      chk("last_word_rdata", f0.rdata, 32'h1000_003F);
      cyc();
      chk("err_idle_qual", 32'(f0.err), 32'h0);

      // Reset in the middle of a fetch on u0
      f0.req = 1'b1; f0.addr = 32'h8;
      #1;
      chk("rst_mid_gnt", 32'(f0.gnt), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_rdata", f0.rdata, 32'h0);
      cyc();
      chk("rst_mid_rvalid", 32'(f0.rvalid), 32'h0);
      f0.req = 1'b0;
      #2 rst_n = 1'b1;
      cyc();
      chk("rst_post_rvalid", 32'(f0.rvalid), 32'h0);
      f0.req = 1'b1; f0.addr = 32'h4; d0.req = 1'b1; d0.addr = 32'h8;
      #1;
      chk("rst_tie_f_gnt", 32'(f0.gnt), 32'h1);
      chk("rst_tie_d_gnt", 32'(d0.gnt), 32'h0);
      cyc();
      f0.req = 1'b0; d0.req = 1'b0;
      chk("rst_tie_f_rvalid", 32'(f0.rvalid), 32'h1);
      chk("rst_tie_f_rdata", f0.rdata, 32'h1000_0001);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
